mux_seq_n: RTL and testbench
============================

MUX_SEQ_N -- requirements
Module: mux_seq_n

Interface
REQ-001 SHALL have parameter W, default 32: data word width in bits, W >= 1.
REQ-002 SHALL have parameter N, default 4: number of input words, 2 <= N <= 16.
REQ-003 SHALL have derived localparam SELW = clog2(N): width of select and index.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port d_in, input, N*W: packed words; word k = d_in[k*W +: W].
REQ-007 SHALL have port select, input, SELW: word index for direct mode.
REQ-008 SHALL have port mode, input, 1: 0 = direct select, 1 = auto-sequence.
REQ-009 SHALL have port in_valid, input, 1: direct-mode request.
REQ-010 SHALL have port start, input, 1: auto-sequence request.
REQ-011 SHALL have port in_ready, output, 1: request acceptance.
REQ-012 SHALL have port d_out, output, W: registered output word.
REQ-013 SHALL have port out_valid, output, 1: d_out holds a valid word.
REQ-014 SHALL have port out_ready, input, 1: downstream accepts d_out.
REQ-015 SHALL have port index, output, SELW: source index of the current d_out word.
REQ-016 SHALL have port busy, output, 1: high while in state SEQ.
REQ-017 SHALL have port done, output, 1: one-cycle pulse when the last sequenced word is accepted.

Function
REQ-018 SHALL implement two states, IDLE and SEQ; busy = (state == SEQ).
REQ-019 SHALL drive in_ready = (state == IDLE) && (!out_valid || out_ready), combinationally.
REQ-020 Output handshake: a word transfers on a cycle with out_valid && out_ready; while out_valid && !out_ready, d_out and index SHALL hold stable.
REQ-021 Direct mode, IDLE, mode=0, in_valid && in_ready: next edge SHALL load d_out = word[select] and index = select, and set out_valid=1. Latency is 1 cycle.
REQ-022 Direct mode: select >= N SHALL load d_out = 0, with index = select.
REQ-023 Direct mode, IDLE, no accepted request, and out_valid && out_ready: out_valid SHALL clear next edge.
REQ-024 Back-to-back direct requests with out_ready=1 SHALL sustain one word per cycle.
REQ-025 Auto mode, IDLE, mode=1, start && in_ready: SHALL capture all N words of d_in into an internal N*W buffer, set d_out = word[0], index = 0, out_valid = 1, and go to SEQ.
REQ-026 SHALL ignore in_valid while mode=1, and start while mode=0.
REQ-027 SEQ, on transfer with index < N-1: index SHALL increment and d_out = buffer[index+1] next edge; out_valid stays 1.
REQ-028 SEQ, on transfer with index == N-1: SHALL clear out_valid, pulse done for exactly that next cycle, and return to IDLE.
REQ-029 SEQ: d_in, select, mode, start and in_valid SHALL have no effect; emitted words come only from the captured buffer.
REQ-030 A new start SHALL be accepted on the first cycle in_ready is high after done, giving at most one idle cycle between sequences.
REQ-031 index SHALL never exceed N-1 in SEQ; no wrap-around within a sequence.

Reset
REQ-032 While rst=1, asynchronously: state=IDLE, d_out=0, index=0, out_valid=0, done=0, buffer=0; busy=0 and in_ready=1 follow from that state.
REQ-033 Reset asserted mid-sequence SHALL abort the sequence with no done pulse; the first edge after rst deasserts SHALL behave as from IDLE.

Verification
REQ-034 Direct: W=32, N=4, d_in words {A0,B1,C2,D3}, select=2, in_valid=1, out_ready=1 -> next cycle d_out=C2, index=2, out_valid=1.
REQ-035 Backpressure: as REQ-034 with out_ready=0 for 3 cycles -> d_out=C2 held, in_ready=0; on out_ready=1, transfer occurs and in_ready=1.
REQ-036 Sequence: mode=1, start pulse, out_ready=1, d_in changed to all-0xFF after capture -> d_out A0,B1,C2,D3 on 4 consecutive cycles, index 0..3, done pulses once after D3, busy low afterwards.
REQ-037 Stalled sequence: out_ready toggles 1,0,1,0 -> each word appears exactly once, in order; no word skipped or duplicated.
REQ-038 Reset mid-sequence: rst asserted after word B1 -> out_valid=0, busy=0, d_out=0 immediately, and no done pulse.
REQ-039 Non-power-of-2: N=3, select=3 in direct mode -> d_out=0; auto mode emits exactly 3 words.

Source files
------------

// File: rtl/mux_seq_n.sv
// mux_seq_n: registered N-to-1 word multiplexer with a direct-select mode and an
// auto-sequence mode that snapshots all N input words and streams them out in order.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   d_in       - N packed words, word k = d_in[k*W +: W]
//   select     - word index for a direct-mode request
//   mode       - 0 = direct select, 1 = auto-sequence
//   in_valid   - direct-mode request (ignored when mode = 1)
//   start      - auto-sequence request (ignored when mode = 0)
//   in_ready   - request accepted this cycle if high
//   d_out      - registered output word
//   out_valid  - d_out holds a valid word
//   out_ready  - downstream accepts d_out
//   index      - source index of the current d_out word
//   busy       - high while a sequence is being emitted
//   done       - one-cycle pulse after the last sequenced word is accepted
module mux_seq_n #(
    parameter int unsigned W = 32,
    parameter int unsigned N = 4,
    localparam int unsigned SELW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*W-1:0]    d_in,
    input  logic [SELW-1:0]   select,
    input  logic              mode,
    input  logic              in_valid,
    input  logic              start,
    output logic              in_ready,
    output logic [W-1:0]      d_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SELW-1:0]   index,
    output logic              busy,
    output logic              done
);

    localparam logic [SELW-1:0] LastIdx = SELW'(N - 1);

    typedef enum logic [0:0] {StIdle, StSeq} state_e;

    state_e            state_q, state_d;
    logic [N*W-1:0]    buf_q, buf_d;
    logic [W-1:0]      d_out_q, d_out_d;
    logic [SELW-1:0]   index_q, index_d;
    logic              out_valid_q, out_valid_d;
    logic              done_q, done_d;

    logic              xfer;
    logic [SELW-1:0]   next_idx;
    logic [W-1:0]      sel_word;
    logic [W-1:0]      seq_word;

    assign xfer     = out_valid_q && out_ready;
    assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);
    assign next_idx = index_q + SELW'(1);

    // Decoded word lookups; an out-of-range select (non power-of-two N) yields zero.
    always_comb begin
        sel_word = '0;
        seq_word = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (select == SELW'(k)) begin
                sel_word = d_in[k*W +: W];
            end
            if (next_idx == SELW'(k)) begin
                seq_word = buf_q[k*W +: W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        d_out_d     = d_out_q;
        index_d     = index_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!mode && in_valid && in_ready) begin
                    d_out_d     = sel_word;
                    index_d     = select;
                    out_valid_d = 1'b1;
                end else if (mode && start && in_ready) begin
                    buf_d       = d_in;
                    d_out_d     = d_in[W-1:0];
                    index_d     = '0;
                    out_valid_d = 1'b1;
                    state_d     = StSeq;
                end else if (xfer) begin
                    out_valid_d = 1'b0;
                end
            end
            StSeq: begin
                // out_valid stays high for the whole sequence; only transfers advance it.
                if (xfer) begin
                    if (index_q == LastIdx) begin
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        index_d = next_idx;
                        d_out_d = seq_word;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            buf_q       <= '0;
            d_out_q     <= '0;
            index_q     <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            d_out_q     <= d_out_d;
            index_q     <= index_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign d_out     = d_out_q;
    assign index     = index_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == StSeq);
    assign done      = done_q;

endmodule

// File: tb/tb_mux_seq_n.sv
// tb_mux_seq_n: self-checking bench for mux_seq_n (N=4/W=32 and N=3/W=8 instances).
module tb_mux_seq_n;

    localparam logic [127:0] DinBase = {32'hD3, 32'hC2, 32'hB1, 32'hA0};
    localparam logic [23:0]  Din3    = {8'h33, 8'h22, 8'h11};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // N=4, W=32 instance
    logic [127:0] d_in4;
    logic [1:0]   sel4;
    logic         md4, iv4, st4, ordy4;
    logic         rdy4, v4, busy4, done4;
    logic [31:0]  dout4;
    logic [1:0]   idx4;

    // N=3, W=8 instance
    logic [23:0]  d_in3;
    logic [1:0]   sel3;
    logic         md3, iv3, st3, ordy3;
    logic         rdy3, v3, busy3, done3;
    logic [7:0]   dout3;
    logic [1:0]   idx3;

    mux_seq_n #(.W(32), .N(4)) dut4 (
        .clk(clk), .rst(rst), .d_in(d_in4), .select(sel4), .mode(md4),
        .in_valid(iv4), .start(st4), .in_ready(rdy4), .d_out(dout4),
        .out_valid(v4), .out_ready(ordy4), .index(idx4), .busy(busy4), .done(done4)
    );

    mux_seq_n #(.W(8), .N(3)) dut3 (
        .clk(clk), .rst(rst), .d_in(d_in3), .select(sel3), .mode(md3),
        .in_valid(iv3), .start(st3), .in_ready(rdy3), .d_out(dout3),
        .out_valid(v3), .out_ready(ordy3), .index(idx3), .busy(busy3), .done(done3)
    );

    int nerr = 0;
    int nchk = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        md, iv, st;
        logic [1:0]  sel;
        logic        ordy, dff;
        logic        e_rdy, e_v;
        logic [31:0] e_dout;
        logic [1:0]  e_idx;
        logic        e_busy, e_done;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(logic md, logic iv, logic st, logic [1:0] sel, logic ordy,
                                logic dff, logic rdy, logic v, logic [31:0] dout,
                                logic [1:0] idx, logic b, logic d);
        vec_t r;
        r.md = md; r.iv = iv; r.st = st; r.sel = sel; r.ordy = ordy; r.dff = dff;
        r.e_rdy = rdy; r.e_v = v; r.e_dout = dout; r.e_idx = idx; r.e_busy = b; r.e_done = d;
        return r;
    endfunction

    task automatic drive4(input logic md, input logic iv, input logic st, input logic [1:0] sel,
                          input logic ordy, input logic [127:0] din);
        md4 = md; iv4 = iv; st4 = st; sel4 = sel; ordy4 = ordy; d_in4 = din;
    endtask

    // Reference model: a transaction-level view with a queue of words still to emit.
    logic        m_v, m_b, m_d;
    logic [31:0] m_dout;
    logic [1:0]  m_idx;
    logic [31:0] m_q[$];

    function automatic logic m_rdy();
        return !m_b && (!m_v || ordy4);
    endfunction

    task automatic model_reset();
        m_v = 0; m_b = 0; m_d = 0; m_dout = 0; m_idx = 0; m_q.delete();
    endtask

    task automatic model_step();
        logic acc, xf;
        acc = m_rdy();
        xf  = m_v && ordy4;
        m_d = 0;
        if (m_b) begin
            if (xf) begin
                if (m_q.size() == 0) begin
                    m_v = 0; m_b = 0; m_d = 1;
                end else begin
                    m_dout = m_q.pop_front();
                    m_idx  = m_idx + 2'd1;
                end
            end
        end else if (acc && !md4 && iv4) begin
            m_v = 1; m_idx = sel4; m_dout = d_in4[int'(sel4)*32 +: 32];
        end else if (acc && md4 && st4) begin
            m_q.delete();
            for (int k = 1; k < 4; k++) m_q.push_back(d_in4[k*32 +: 32]);
            m_dout = d_in4[31:0]; m_idx = 0; m_v = 1; m_b = 1;
        end else if (xf) begin
            m_v = 0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drive4(0, 0, 0, 0, 0, DinBase);
        md3 = 0; iv3 = 0; st3 = 0; sel3 = 0; ordy3 = 0; d_in3 = Din3;

        //            md iv st sel ordy dff | rdy v  dout     idx busy done
        tbl[0]  = mk(0, 1, 0, 2, 1, 0,   1, 1, 32'hC2, 2, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0,   0, 1, 32'hC2, 2, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0,   0, 1, 32'hC2, 2, 0, 0);
        tbl[3]  = mk(0, 1, 0, 1, 0, 0,   0, 1, 32'hC2, 2, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 1, 0,   1, 0, 32'h00, 0, 0, 0);
        tbl[5]  = mk(0, 1, 0, 0, 1, 0,   1, 1, 32'hA0, 0, 0, 0);
        tbl[6]  = mk(0, 1, 0, 3, 1, 0,   1, 1, 32'hD3, 3, 0, 0);
        tbl[7]  = mk(1, 1, 0, 1, 1, 0,   1, 0, 32'h00, 0, 0, 0);
        tbl[8]  = mk(0, 0, 1, 0, 1, 0,   1, 0, 32'h00, 0, 0, 0);
        tbl[9]  = mk(1, 0, 1, 0, 1, 0,   1, 1, 32'hA0, 0, 1, 0);
        tbl[10] = mk(1, 0, 0, 0, 1, 1,   0, 1, 32'hB1, 1, 1, 0);
        tbl[11] = mk(0, 1, 1, 2, 1, 1,   0, 1, 32'hC2, 2, 1, 0);
        tbl[12] = mk(1, 0, 0, 0, 1, 1,   0, 1, 32'hD3, 3, 1, 0);
        tbl[13] = mk(1, 0, 0, 0, 1, 1,   0, 0, 32'h00, 0, 0, 1);
        tbl[14] = mk(1, 0, 1, 0, 0, 0,   1, 1, 32'hA0, 0, 1, 0);
        tbl[15] = mk(1, 0, 0, 0, 0, 0,   0, 1, 32'hA0, 0, 1, 0);
        tbl[16] = mk(1, 0, 0, 0, 1, 0,   0, 1, 32'hB1, 1, 1, 0);
        tbl[17] = mk(1, 0, 0, 0, 0, 0,   0, 1, 32'hB1, 1, 1, 0);
        tbl[18] = mk(1, 0, 0, 0, 1, 0,   0, 1, 32'hC2, 2, 1, 0);
        tbl[19] = mk(1, 0, 0, 0, 0, 0,   0, 1, 32'hC2, 2, 1, 0);
        tbl[20] = mk(1, 0, 0, 0, 1, 0,   0, 1, 32'hD3, 3, 1, 0);
        tbl[21] = mk(1, 0, 0, 0, 0, 0,   0, 1, 32'hD3, 3, 1, 0);
        tbl[22] = mk(1, 0, 0, 0, 1, 0,   0, 0, 32'h00, 0, 0, 1);
        tbl[23] = mk(0, 0, 0, 0, 1, 0,   1, 0, 32'h00, 0, 0, 0);

        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(v4), 0);
        chk("rst_dout", dout4, 0);
        chk("rst_index", 32'(idx4), 0);
        chk("rst_busy", 32'(busy4), 0);
        chk("rst_done", 32'(done4), 0);
        chk("rst_in_ready", 32'(rdy4), 1);
        chk("rst_valid_n3", 32'(v3), 0);
        rst = 1'b0;

        // Directed table on the N=4 instance.
        for (int i = 0; i < 24; i++) begin
            drive4(tbl[i].md, tbl[i].iv, tbl[i].st, tbl[i].sel, tbl[i].ordy,
                   tbl[i].dff ? {128{1'b1}} : DinBase);
            #1;
            chk($sformatf("row%0d_in_ready", i), 32'(rdy4), 32'(tbl[i].e_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_valid", i), 32'(v4), 32'(tbl[i].e_v));
            chk($sformatf("row%0d_busy", i), 32'(busy4), 32'(tbl[i].e_busy));
            chk($sformatf("row%0d_done", i), 32'(done4), 32'(tbl[i].e_done));
            if (tbl[i].e_v) begin
                chk($sformatf("row%0d_dout", i), dout4, tbl[i].e_dout);
                chk($sformatf("row%0d_index", i), 32'(idx4), 32'(tbl[i].e_idx));
            end
            @(negedge clk);
        end

        // Reset asserted mid-sequence, right after B1 is presented.
        drive4(1, 0, 1, 0, 1, DinBase);
        @(posedge clk); #1;
        chk("abort_w0", dout4, 32'hA0);
        @(negedge clk);
        st4 = 0;
        @(posedge clk); #1;
        chk("abort_w1", dout4, 32'hB1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_valid", 32'(v4), 0);
        chk("abort_busy", 32'(busy4), 0);
        chk("abort_dout", dout4, 0);
        chk("abort_in_ready", 32'(rdy4), 1);
        @(posedge clk); #1;
        chk("abort_done_in_rst", 32'(done4), 0);
        @(negedge clk);
        rst = 1'b0;
        drive4(0, 1, 0, 1, 1, DinBase);
        @(posedge clk); #1;
        chk("post_abort_done", 32'(done4), 0);
        chk("post_abort_dout", dout4, 32'hB1);
        chk("post_abort_index", 32'(idx4), 1);
        @(negedge clk);
        drive4(0, 0, 0, 0, 1, DinBase);

        // N=3: out-of-range select, then a three-word sequence.
        md3 = 0; iv3 = 1; sel3 = 2'd3; ordy3 = 1;
        @(posedge clk); #1;
        chk("n3_sel3_dout", 32'(dout3), 0);
        chk("n3_sel3_index", 32'(idx3), 3);
        chk("n3_sel3_valid", 32'(v3), 1);
        @(negedge clk);
        md3 = 1; iv3 = 0; st3 = 1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            st3 = 0;
            chk($sformatf("n3_seq%0d_dout", k), 32'(dout3), 32'(Din3[k*8 +: 8]));
            chk($sformatf("n3_seq%0d_index", k), 32'(idx3), k);
            chk($sformatf("n3_seq%0d_busy", k), 32'(busy3), 1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        chk("n3_end_valid", 32'(v3), 0);
        chk("n3_end_done", 32'(done3), 1);
        chk("n3_end_busy", 32'(busy3), 0);
        @(negedge clk);
        md3 = 0; ordy3 = 0;

        // Randomized traffic against the reference model.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 400; c++) begin
            drive4(1'($urandom % 2), 1'($urandom % 2), 1'(($urandom % 3) == 0),
                   2'($urandom % 4), 1'(($urandom % 4) != 0),
                   {$urandom, $urandom, $urandom, $urandom});
            #1;
            chk($sformatf("rnd%0d_in_ready", c), 32'(rdy4), 32'(m_rdy()));
            @(posedge clk);
            model_step();
            #1;
            chk($sformatf("rnd%0d_valid", c), 32'(v4), 32'(m_v));
            chk($sformatf("rnd%0d_busy", c), 32'(busy4), 32'(m_b));
            chk($sformatf("rnd%0d_done", c), 32'(done4), 32'(m_d));
            if (m_v) begin
                chk($sformatf("rnd%0d_dout", c), dout4, m_dout);
                chk($sformatf("rnd%0d_index", c), 32'(idx4), 32'(m_idx));
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
